// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl -- control FSM for a sequential shift-add multiplier.
//
// Sequences an external N-bit shift-add datapath: LOAD the operands, then
// for each multiplier bit TEST the LSB, optionally ADD the multiplicand,
// and SHIFT. A one-cycle done pulse marks the end of a multiply. valid
// stays high from then until the next LOAD.
//
// Optional feature, selected by the macro MUL_SEQ_CTRL_ZERO_SKIP_EN:
//   When defined, a TEST that sees the remaining multiplier bits all zero
//   (yz=1) finishes at once instead of walking through the remaining
//   bits. When undefined, yz is ignored and every multiply takes exactly
//   N SHIFT cycles.

module mul_seq_ctrl #(
    parameter int N = 4
) (
    input  logic clk,
    input  logic rst,        // asynchronous, active low
    input  logic start,
    input  logic q0,
    input  logic yz,
    output logic ld,
    output logic add_en,
    output logic shift_en,
    output logic busy,
    output logic done,
    output logic valid
);

    localparam int            CW   = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_TEST,
        S_ADD,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic          r_start_d;
    logic          r_valid;
    logic          w_trigger;

`ifndef MUL_SEQ_CTRL_ZERO_SKIP_EN
    // yz has no role when the early-finish feature is compiled out.
    logic w_unused_yz;
    assign w_unused_yz = yz;
`endif

    // Rising edge of the start level. The delayed copy resets to 1, so a
    // start already held high when reset releases is not taken as a request.
    assign w_trigger = start & ~r_start_d;

    // State, step counter and start-edge history registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_start_d <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_start_d <= start;
        end
    end

    // Next-state and counter logic. Strobes decode r_state alone (Moore),
    // and each strobe belongs to exactly one state, so at most one of
    // ld/add_en/shift_en is ever high.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        ld           = 1'b0;
        add_en       = 1'b0;
        shift_en     = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                // Edges seen outside IDLE are simply dropped.
                if (w_trigger) begin
                    w_state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                ld           = 1'b1;
                w_cnt_next   = '0;
                w_state_next = S_TEST;
            end
            S_TEST: begin
`ifdef MUL_SEQ_CTRL_ZERO_SKIP_EN
                if (yz) begin
                    w_state_next = S_DONE;
                end else if (q0) begin
                    w_state_next = S_ADD;
                end else begin
                    w_state_next = S_SHIFT;
                end
`else
                if (q0) begin
                    w_state_next = S_ADD;
                end else begin
                    w_state_next = S_SHIFT;
                end
`endif
            end
            S_ADD: begin
                add_en       = 1'b1;
                w_state_next = S_SHIFT;
            end
            S_SHIFT: begin
                shift_en = 1'b1;
                if (r_cnt == LAST) begin
                    w_state_next = S_DONE;
                end else begin
                    w_cnt_next   = r_cnt + CW'(1);
                    w_state_next = S_TEST;
                end
            end
            S_DONE: begin
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                busy         = 1'b0;
                w_state_next = S_IDLE;
            end
        endcase
    end

    // valid rises as DONE is left and drops as the next LOAD is entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
        end else if (r_state == S_DONE) begin
            r_valid <= 1'b1;
        end else if (w_state_next == S_LOAD) begin
            r_valid <= 1'b0;
        end
    end

    assign valid = r_valid;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Testbench for mul_seq_ctrl with an N=4 shift-add datapath model.
// Expected results are queued when a multiply is launched and checked when
// the controller pulses done.

module tb_mul_seq_ctrl;

    localparam int N = 4;

    logic clk;
    logic rst;
    logic start;
    logic q0;
    logic yz;
    logic ld;
    logic add_en;
    logic shift_en;
    logic busy;
    logic done;
    logic valid;

    int n_tests;
    int n_fail;

    // Datapath model: {carry, A, Q} shift register plus remaining multiplier.
    logic [4:0] m_ca;
    logic [3:0] m_q;
    logic [3:0] m_x;
    logic [3:0] m_yrem;
    int         m_nshift;

    assign q0 = m_q[0];
    assign yz = (m_yrem == 4'd0);

    typedef struct {
        int prod;
        int done_cyc;
        int adds;
        int shifts;
        int first_add;
    } exp_t;

    exp_t sb[$];

    mul_seq_ctrl #(.N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .q0       (q0),
        .yz       (yz),
        .ld       (ld),
        .add_en   (add_en),
        .shift_en (shift_en),
        .busy     (busy),
        .done     (done),
        .valid    (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp_v);
        end
    endtask

    function automatic int outs_vec();
        return int'({ld, add_en, shift_en, busy, done, valid});
    endfunction

    // Number of multiplier bits actually walked before finishing.
    function automatic int bits_walked(input logic [3:0] y);
`ifdef MUL_SEQ_CTRL_ZERO_SKIP_EN
        int k;
        k = 0;
        for (int i = 0; i < N; i++) if (y[i]) k = i + 1;
        return k;
`else
        return (y == 4'd0) ? N : N;
`endif
    endfunction

    function automatic int exp_done_cycle(input logic [3:0] y);
        int k;
        int pc;
        k  = bits_walked(y);
        pc = $countones(y);
        if (k < N) return 3 + 2 * k + pc;
        return 2 + 2 * k + pc;
    endfunction

    function automatic int exp_first_add(input logic [3:0] y);
        int pc;
        pc = 0;
        for (int i = 0; i < N; i++) begin
            if (y[i]) return 2 + 2 * i + pc + 1;
        end
        return 0;
    endfunction

    // One multiply: launch on a fresh start edge, follow the strobes cycle by
    // cycle, then check against the queued expectation. abort_at>0 pulls
    // reset in that cycle. retrig toggles start while busy and leaves it high.
    task automatic run_mul(input logic [3:0] x, input logic [3:0] y,
                           input int abort_at, input bit retrig);
        exp_t e;
        int   ld_n;
        int   ld_cyc;
        int   add_n;
        int   first_add;
        int   sh_n;
        int   done_cyc;
        int   prod;
        logic [8:0] t;

        e.prod      = int'(x) * int'(y);
        e.done_cyc  = exp_done_cycle(y);
        e.adds      = $countones(y);
        e.shifts    = bits_walked(y);
        e.first_add = exp_first_add(y);
        sb.push_back(e);

        ld_n = 0; ld_cyc = 0; add_n = 0; first_add = 0; sh_n = 0;
        done_cyc = 0; prod = -1;

        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            check("strobe_onehot", int'(ld) + int'(add_en) + int'(shift_en) <= 1 ? 1 : 0, 1);
            check("busy_during", int'(busy), 1);
            if (cyc == 1) check("valid_at_load", int'(valid), 0);
            if (ld) begin
                ld_n++; ld_cyc = cyc;
                m_ca = 5'd0; m_q = y; m_yrem = y; m_x = x; m_nshift = 0;
            end
            if (add_en) begin
                add_n++;
                if (first_add == 0) first_add = cyc;
                m_ca = {1'b0, m_ca[3:0]} + {1'b0, m_x};
            end
            if (shift_en) begin
                sh_n++;
                t = {m_ca, m_q} >> 1;
                m_ca = t[8:4]; m_q = t[3:0];
                m_yrem = m_yrem >> 1;
                m_nshift++;
            end
            if (done) begin
                done_cyc = cyc;
                t = {m_ca, m_q} >> (N - m_nshift);
                prod = int'(t);
                break;
            end
            if (retrig && cyc == 3) start = 1'b0;
            if (retrig && cyc == 5) start = 1'b1;
            if (cyc == abort_at) begin
                rst = 1'b0;
                #1;
                check("abort_outs_zero", outs_vec(), 0);
                sb.delete();
                for (int k = 0; k < 2; k++) begin
                    @(negedge clk);
                    check("abort_no_done", int'(done) + int'(busy), 0);
                end
                rst = 1'b1;
                $display("[TB] x=%0d y=%0d aborted by reset in cycle %0d", x, y, cyc);
                return;
            end
        end

        if (done_cyc == 0) begin
            check("done_timeout", 0, 1);
            sb.delete();
            return;
        end
        e = sb.pop_front();
        check("done_cycle", done_cyc, e.done_cyc);
        check("product", prod, e.prod);
        check("ld_count", ld_n, 1);
        check("ld_cycle", ld_cyc, 1);
        check("add_count", add_n, e.adds);
        check("first_add_cycle", first_add, e.first_add);
        check("shift_count", sh_n, e.shifts);
        @(negedge clk);
        check("valid_after", int'(valid), 1);
        check("busy_after", int'(busy), 0);
        check("done_pulse_len", int'(done), 0);
        $display("[TB] x=%0d y=%0d done_cycle=%0d product=%0d adds=%0d shifts=%0d",
                 x, y, done_cyc, prod, add_n, sh_n);
        if (!retrig) start = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        m_ca = 5'd0; m_q = 4'd0; m_x = 4'd0; m_yrem = 4'd0; m_nshift = 0;
        rst   = 1'b0;
        start = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset_outs", outs_vec(), 0);
        rst = 1'b1;
        @(negedge clk);
        check("post_reset_outs", outs_vec(), 0);
        $display("[TB] reset released, outputs idle");

        // Basic multiplies.
        run_mul(4'd3, 4'd2, 0, 1'b0);
        run_mul(4'd15, 4'd15, 0, 1'b0);
        run_mul(4'd7, 4'd0, 0, 1'b0);

        // Edge while busy is dropped; start held after DONE does not restart.
        run_mul(4'd6, 4'd5, 0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("held_start_no_ld", int'(ld) + int'(busy), 0);
        end
        $display("[TB] start held high after done: no restart");
        run_mul(4'd5, 4'd3, 0, 1'b0);

        // Reset mid-multiply with start held through it, then a fresh start.
        run_mul(4'd5, 4'd4, 5, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("held_through_reset", int'(ld) + int'(busy) + int'(valid), 0);
        end
        run_mul(4'd5, 4'd4, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_seq_ctrl.md
MUL_SEQ_CTRL -- requirements
Module: mul_seq_ctrl

Interface
REQ-001 SHALL have parameter: N, default 4, operand width in bits of the controlled shift-add datapath (legal N >= 2).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: start  input  1  debounced button level; a 0->1 transition requests a multiply.
REQ-005 SHALL have port: q0  input  1  LSB of the datapath multiplier register (current bit under test).
REQ-006 SHALL have port: yz  input  1  datapath flag: remaining multiplier bits all zero (used only under REQ-025).
REQ-007 SHALL have port: ld  output  1  load X/Y operands into datapath and clear accumulator.
REQ-008 SHALL have port: add_en  output  1  add multiplicand into accumulator high half.
REQ-009 SHALL have port: shift_en  output  1  shift accumulator/multiplier right by one.
REQ-010 SHALL have port: busy  output  1  high from LOAD through DONE inclusive.
REQ-011 SHALL have port: done  output  1  one-cycle pulse; product complete, latch it into the display register.
REQ-012 SHALL have port: valid  output  1  product on datapath is final; held until next LOAD.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, TEST, ADD, SHIFT, DONE, with a step counter of clog2(N) bits.
REQ-014 SHALL register start into start_d every cycle; trigger = start & ~start_d, evaluated only in IDLE.
REQ-015 IDLE: trigger -> LOAD; otherwise stay; triggers in any other state SHALL be ignored, not queued.
REQ-016 LOAD: ld=1 for exactly one cycle, counter <= 0, -> TEST.
REQ-017 TEST: no strobes; q0=1 -> ADD, q0=0 -> SHIFT.
REQ-018 ADD: add_en=1 for one cycle -> SHIFT.
REQ-019 SHIFT: shift_en=1 for one cycle; counter == N-1 -> DONE, else counter+1 and -> TEST.
REQ-020 DONE: done=1 for one cycle, valid <= 1, -> IDLE; valid SHALL clear on entry to LOAD.
REQ-021 ld, add_en, shift_en, busy, done SHALL be Moore decodes of the state register only; at most one of ld/add_en/shift_en high in any cycle.
REQ-022 Latency: trigger sampled at edge E0 -> LOAD in cycle 1; done in cycle 2 + 2N + popcount(Y) (REQ-025 disabled).
REQ-023 A start held high SHALL NOT retrigger; only a fresh 0->1 edge seen in IDLE starts a new multiply.

Reset
REQ-024 rst low SHALL immediately force IDLE, counter 0, start_d 1 (a start level held through reset does not trigger), valid 0, all outputs 0; reset mid-multiply aborts with no done pulse.

Configuration
REQ-025 Macro MUL_SEQ_CTRL_ZERO_SKIP_EN: when defined, TEST with yz=1 SHALL go directly to DONE (no further ADD/SHIFT); when undefined, yz SHALL be ignored and exactly N SHIFT cycles occur per multiply.

Verification (bench models the N=4 datapath: q0 = current Y LSB, yz = (remaining Y == 0))
REQ-026 X=3, Y=2, start 0->1 -> ld in cycle 1, add_en only in cycle 5, four shift_en pulses, done in cycle 11, product 6.
REQ-027 X=15, Y=15 -> four add_en pulses, done in cycle 14, product 225, valid high after DONE.
REQ-028 X=7, Y=0, ZERO_SKIP_EN undefined -> no add_en, done in cycle 10; defined -> LOAD, TEST, done in cycle 3, product 0.
REQ-029 Second start edge during busy, then start held high after DONE -> no extra ld, no restart until start returns to 0 and rises again.
REQ-030 rst low in cycle 5 of X=5, Y=4 -> all outputs 0 immediately, no done; fresh start after release -> done in cycle 11, product 20.
